// File: rtl/fir_output_buffer.sv
// Output stage for the FIR filter: rounds and saturates each captured sample to OUT_WIDTH
// and buffers it in a first-word-fall-through FIFO presented on a valid/ready stream.
module fir_output_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [DATA_WIDTH-1:0]         iv_din,
    input  logic                          i_din_valid,
    output logic                          o_ready,
    output logic [OUT_WIDTH-1:0]          ov_dout,
    output logic                          o_dout_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ov_level,
    output logic                          o_sat
);

    localparam int SH = DATA_WIDTH - OUT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        ARMED    = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_t;

    cap_state_t state_q, state_d;

    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;

    logic [OUT_WIDTH-1:0] conv;
    logic                 conv_sat;
    logic                 capture;
    logic                 pop;

    // Sample conversion: round half up, then clamp to the signed output range.
    generate
        if (SH == 0) begin : g_pass
            always_comb begin
                conv     = iv_din;
                conv_sat = 1'b0;
            end
        end else begin : g_round
            localparam logic [DATA_WIDTH:0] RND = (DATA_WIDTH + 1)'(1) << (SH - 1);
            logic [DATA_WIDTH:0] t;
            logic [OUT_WIDTH:0]  r;
            logic                frac_unused;

            always_comb begin
                t           = {iv_din[DATA_WIDTH-1], iv_din} + RND;
                r           = t[DATA_WIDTH:SH];
                frac_unused = ^t[SH-1:0];
                conv        = r[OUT_WIDTH-1:0];
                conv_sat    = 1'b0;
                if (r[OUT_WIDTH] != r[OUT_WIDTH-1]) begin
                    conv_sat = 1'b1;
                    conv     = r[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
        end
    endgenerate

    // Fullness uses the pre-edge level, so a full buffer never accepts alongside a pop.
    always_comb begin
        capture = i_en && (state_q == ARMED) && i_din_valid && (ov_level < LW'(FIFO_DEPTH));
        pop     = i_en && o_dout_valid && i_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED:    if (capture) state_d = WAIT_LOW;
            WAIT_LOW: if (i_en && !i_din_valid) state_d = ARMED;
            default:  state_d = ARMED;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture) begin
            mem[wr_ptr_q] <= conv;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ov_level     <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            o_ready      <= 1'b0;
            o_sat        <= 1'b0;
        end else if (!i_en) begin
            o_ready <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_ready <= capture;
            o_sat   <= capture && conv_sat;

            if (capture) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end

            case ({capture, pop})
                2'b10:   ov_level <= ov_level + LW'(1);
                2'b01:   ov_level <= ov_level - LW'(1);
                default: ov_level <= ov_level;
            endcase

            // Head register reloads one edge after a pop, giving a one-cycle valid gap.
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PW'(1);
                o_dout_valid <= 1'b0;
            end else if (!o_dout_valid && (ov_level != '0)) begin
                ov_dout      <= mem[rd_ptr_q];
                o_dout_valid <= 1'b1;
            end
        end
    end

endmodule
